mem_arbiter: RTL and testbench

- Parametrised memory controller that replaces the fixed two-requestor controller (ICache + SLB).
- Accepts NUM_CH independent request channels and arbitrates among them round-robin.
- Serialises each 1/2/4-byte access onto the 8-bit memory bus (read data returns one cycle after the address).
- Handles UART back-pressure and aborts speculative reads on a mispredict flush.

---
 rtl/mem_arbiter_if.sv | 28 ++
 rtl/mem_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request channels and byte-wide memory bus of mem_arbiter.
// The master side is the requestors plus the memory; the slave side is the arbiter.
interface mem_arbiter_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 32
);
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_wr;
  logic [ADDR_W*NUM_CH-1:0] ch_addr;
  logic [3*NUM_CH-1:0]      ch_size;
  logic [32*NUM_CH-1:0]     ch_wdata;
  logic [31:0]              ch_rdata;
  logic [NUM_CH-1:0]        ch_done;
  logic [7:0]               mem_din;
  logic [7:0]               mem_dout;
  logic [ADDR_W-1:0]        mem_a;
  logic                     mem_wr;

  modport master (
    output ch_valid, ch_wr, ch_addr, ch_size, ch_wdata, mem_din,
    input  ch_rdata, ch_done, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  ch_valid, ch_wr, ch_addr, ch_size, ch_wdata, mem_din,
    output ch_rdata, ch_done, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter serialising 1/2/4-byte channel accesses onto
// an 8-bit memory bus, with UART back-pressure and mispredict-flush abort of reads.
// Optional macro MEMC_PIPELINE_EN: overlap the next grant with the finishing
// transaction so ch_done and the next first address share a cycle.
module mem_arbiter #(
  parameter int                NUM_CH     = 3,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = 3'b110,
  parameter int                ADDR_W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rdy,
  input  logic         flush,
  input  logic         io_buffer_full,
  mem_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CH);
`ifdef MEMC_PIPELINE_EN
  localparam bit PIPELINE = 1'b1;
`else
  localparam bit PIPELINE = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2, S_IO_WAIT = 2'd3} state_t;

  state_t              state_r, state_nxt_s;
  logic [2:0]          cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [2:0]          size_r, size_nxt_s;
  logic [IDX_W-1:0]    rr_ptr_r, rr_ptr_nxt_s, owner_r, owner_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s, mem_a_r, mem_a_nxt_s;
  logic [31:0]         wdata_r, wdata_nxt_s, rdata_r, rdata_nxt_s;
  logic                io_r, io_nxt_s, mem_wr_r, mem_wr_nxt_s;
  logic [7:0]          mem_dout_r, mem_dout_nxt_s;
  logic [NUM_CH-1:0]   done_r, done_nxt_s, owner_hot_s, req_s;
  logic                gnt_valid_s, take_s, finish_s, sel_wr_s, sel_io_s;
  logic [IDX_W-1:0]    gnt_idx_s, cand_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [2:0]          sel_size_raw_s;
  logic [31:0]         sel_wdata_s;

  // Unsupported sizes are treated as single-byte accesses
  function automatic logic [2:0] norm_size(input logic [2:0] s);
    case (s)
      3'd2:    norm_size = 3'd2;
      3'd4:    norm_size = 3'd4;
      default: norm_size = 3'd1;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [2:0] k);
    case (k)
      3'd0:    byte_of = w[7:0];
      3'd1:    byte_of = w[15:8];
      3'd2:    byte_of = w[23:16];
      3'd3:    byte_of = w[31:24];
      default: byte_of = 8'h00;
    endcase
  endfunction

  // Byte 0 clears the word so short reads return zero upper bytes
  function automatic logic [31:0] put_byte(input logic [31:0] r, input logic [2:0] k,
                                           input logic [7:0] b);
    case (k)
      3'd0:    put_byte = {24'h000000, b};
      3'd1:    put_byte = {r[31:16], b, r[7:0]};
      3'd2:    put_byte = {r[31:24], b, r[15:0]};
      3'd3:    put_byte = {b, r[23:0]};
      default: put_byte = r;
    endcase
  endfunction

  // Round-robin search upward from rr_ptr+1; flushable channels are masked during flush
  always_comb begin
    if (flush) begin
      req_s = bus.ch_valid & ~FLUSH_MASK;
    end else begin
      req_s = bus.ch_valid;
    end
    gnt_valid_s = 1'b0;
    gnt_idx_s   = {IDX_W{1'b0}};
    cand_s      = {IDX_W{1'b0}};
    for (int i = 1; i <= NUM_CH; i++) begin
      cand_s      = IDX_W'((int'(rr_ptr_r) + i) % NUM_CH);
      gnt_idx_s   = (req_s[cand_s] && !gnt_valid_s) ? cand_s : gnt_idx_s;
      gnt_valid_s = gnt_valid_s | req_s[cand_s];
    end
  end

  // Mux the granted channel's request fields
  always_comb begin
    sel_addr_s     = {ADDR_W{1'b0}};
    sel_size_raw_s = 3'd0;
    sel_wr_s       = 1'b0;
    sel_wdata_s    = 32'h00000000;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_addr_s     = sel_addr_s | (bus.ch_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{gnt_idx_s == IDX_W'(i)}});
      sel_size_raw_s = sel_size_raw_s | (bus.ch_size[i*3 +: 3] & {3{gnt_idx_s == IDX_W'(i)}});
      sel_wr_s       = sel_wr_s | (bus.ch_wr[i] & (gnt_idx_s == IDX_W'(i)));
      sel_wdata_s    = sel_wdata_s | (bus.ch_wdata[i*32 +: 32] & {32{gnt_idx_s == IDX_W'(i)}});
    end
    sel_io_s = sel_wr_s && (sel_addr_s[17:16] == 2'b11);
  end

  assign owner_hot_s = {{(NUM_CH-1){1'b0}}, 1'b1} << owner_r;
  assign cnt_inc_s   = cnt_r + 3'd1;

  // Transaction FSM: next state and next values of all registered outputs
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    size_nxt_s     = size_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    owner_nxt_s    = owner_r;
    addr_nxt_s     = addr_r;
    wdata_nxt_s    = wdata_r;
    io_nxt_s       = io_r;
    mem_a_nxt_s    = mem_a_r;
    mem_dout_nxt_s = mem_dout_r;
    mem_wr_nxt_s   = 1'b0;
    done_nxt_s     = {NUM_CH{1'b0}};
    rdata_nxt_s    = rdata_r;
    take_s         = 1'b0;
    finish_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        take_s = gnt_valid_s;
      end
      S_READ: begin
        if (flush && FLUSH_MASK[owner_r]) begin
          state_nxt_s = S_IDLE;
        end else begin
          // byte k-1 arrives while address k (or nothing) is on the bus
          rdata_nxt_s = (cnt_r == 3'd0) ? rdata_r : put_byte(rdata_r, cnt_r - 3'd1, bus.mem_din);
          if (cnt_r == size_r) begin
            state_nxt_s = S_IDLE;
            done_nxt_s  = owner_hot_s;
            finish_s    = 1'b1;
          end else begin
            cnt_nxt_s   = cnt_inc_s;
            mem_a_nxt_s = (cnt_inc_s < size_r) ? addr_r + ADDR_W'(cnt_inc_s) : mem_a_r;
          end
        end
      end
      S_WRITE: begin
        if (cnt_inc_s == size_r) begin
          state_nxt_s = S_IDLE;
          done_nxt_s  = owner_hot_s;
          finish_s    = 1'b1;
        end else if (io_r && io_buffer_full) begin
          cnt_nxt_s   = cnt_inc_s;
          state_nxt_s = S_IO_WAIT;
        end else begin
          cnt_nxt_s      = cnt_inc_s;
          mem_a_nxt_s    = addr_r + ADDR_W'(cnt_inc_s);
          mem_dout_nxt_s = byte_of(wdata_r, cnt_inc_s);
          mem_wr_nxt_s   = 1'b1;
        end
      end
      S_IO_WAIT: begin
        if (io_buffer_full) begin
          state_nxt_s = S_IO_WAIT;
        end else begin
          state_nxt_s    = S_WRITE;
          mem_a_nxt_s    = addr_r + ADDR_W'(cnt_r);
          mem_dout_nxt_s = byte_of(wdata_r, cnt_r);
          mem_wr_nxt_s   = 1'b1;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase

    // Start a new transaction: from IDLE, or overlapped with a finishing one
    if (take_s || (PIPELINE && finish_s && gnt_valid_s)) begin
      rr_ptr_nxt_s = gnt_idx_s;
      owner_nxt_s  = gnt_idx_s;
      addr_nxt_s   = sel_addr_s;
      size_nxt_s   = norm_size(sel_size_raw_s);
      wdata_nxt_s  = sel_wdata_s;
      io_nxt_s     = sel_io_s;
      cnt_nxt_s    = 3'd0;
      if (!sel_wr_s) begin
        state_nxt_s = S_READ;
        mem_a_nxt_s = sel_addr_s;
      end else if (sel_io_s && io_buffer_full) begin
        state_nxt_s = S_IO_WAIT;
      end else begin
        state_nxt_s    = S_WRITE;
        mem_a_nxt_s    = sel_addr_s;
        mem_dout_nxt_s = sel_wdata_s[7:0];
        mem_wr_nxt_s   = 1'b1;
      end
    end else begin
      take_s = 1'b0;
    end
  end

  // State and output registers: synchronous reset, everything frozen while rdy is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      cnt_r      <= 3'd0;
      size_r     <= 3'd1;
      rr_ptr_r   <= IDX_W'(NUM_CH - 1);
      owner_r    <= {IDX_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= 32'h00000000;
      io_r       <= 1'b0;
      mem_a_r    <= {ADDR_W{1'b0}};
      mem_dout_r <= 8'h00;
      mem_wr_r   <= 1'b0;
      done_r     <= {NUM_CH{1'b0}};
      rdata_r    <= 32'h00000000;
    end else if (rdy) begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      size_r     <= size_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      owner_r    <= owner_nxt_s;
      addr_r     <= addr_nxt_s;
      wdata_r    <= wdata_nxt_s;
      io_r       <= io_nxt_s;
      mem_a_r    <= mem_a_nxt_s;
      mem_dout_r <= mem_dout_nxt_s;
      mem_wr_r   <= mem_wr_nxt_s;
      done_r     <= done_nxt_s;
      rdata_r    <= rdata_nxt_s;
    end
  end

  assign bus.ch_rdata = rdata_r;
  assign bus.ch_done  = done_r;
  assign bus.mem_a    = mem_a_r;
  assign bus.mem_dout = mem_dout_r;
  assign bus.mem_wr   = mem_wr_r & rdy;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter (NUM_CH=3) with a one-cycle
// latency byte memory that holds its output while rdy is low.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n, rdy, flush, io_buffer_full;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic [7:0] mem [256];

`ifdef MEMC_PIPELINE_EN
  localparam int EXP_GAP = 2;
`else
  localparam int EXP_GAP = 3;
`endif

  mem_arbiter_if #(.NUM_CH(3), .ADDR_W(32)) bus ();

  mem_arbiter #(.NUM_CH(3), .FLUSH_MASK(3'b110), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .io_buffer_full(io_buffer_full), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // cycle counter for spacing measurements
  always @(posedge clk) cyc <= cyc + 1;

  // byte memory: data for an address appears one cycle later; held while rdy is low
  always @(posedge clk) if (rdy) bus.mem_din <= mem[bus.mem_a[7:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata);
    bus.ch_wr[ch]              = wr;
    bus.ch_addr[ch*32 +: 32]   = addr;
    bus.ch_size[ch*3 +: 3]     = size;
    bus.ch_wdata[ch*32 +: 32]  = wdata;
    bus.ch_valid[ch]           = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    bus.ch_valid = 3'b000; bus.ch_wr = 3'b000;
    bus.ch_addr = '0; bus.ch_size = '0; bus.ch_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0]  rr_exp_done [6];
    logic [31:0] rr_exp_data [6];
    int got, t_first;
    for (int i = 0; i < 256; i++) mem[i] = 8'((i + 1) * 17);
    rr_exp_done = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rr_exp_data = '{32'h21, 32'h31, 32'h41, 32'h21, 32'h31, 32'h41};

    // reset values
    do_reset();
    check("rst_mem_a", bus.mem_a, 32'h0);
    check("rst_mem_dout", {24'h0, bus.mem_dout}, 32'h0);
    check("rst_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
    check("rst_ch_done", {29'h0, bus.ch_done}, 32'h0);
    check("rst_ch_rdata", bus.ch_rdata, 32'h0);

    // ch0 read 0x100 size 4: addresses on cycles 0-3, done at cycle 5
    set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rd4_mem_a", bus.mem_a, 32'h100 + k);
    end
    @(negedge clk);
    check("rd4_no_early_done", {29'h0, bus.ch_done}, 32'h0);
    @(negedge clk);
    check("rd4_done", {29'h0, bus.ch_done}, 32'h1);
    check("rd4_rdata", bus.ch_rdata, 32'h44332211);
    bus.ch_valid = 3'b000;

    // all three channels reading size 1 continuously: round-robin order
    do_reset();
    set_req(0, 1'b0, 32'h10, 3'd1, 32'h0);
    set_req(1, 1'b0, 32'h20, 3'd1, 32'h0);
    set_req(2, 1'b0, 32'h30, 3'd1, 32'h0);
    got = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      @(negedge clk);
      if (bus.ch_done != 3'b000) begin
        check("rr_done", {29'h0, bus.ch_done}, {29'h0, rr_exp_done[got]});
        check("rr_rdata", bus.ch_rdata, rr_exp_data[got]);
        got++;
        if (got == 6) bus.ch_valid = 3'b000;
      end
    end
    check("rr_count", got, 32'd6);

    // I/O write stalled by a full UART buffer for 5 cycles
    do_reset();
    io_buffer_full = 1'b1;
    set_req(1, 1'b1, 32'h30000, 3'd1, 32'h41);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("io_wait_wr", {31'h0, bus.mem_wr}, 32'h0);
    end
    io_buffer_full = 1'b0;
    @(negedge clk);
    check("io_wr", {31'h0, bus.mem_wr}, 32'h1);
    check("io_dout", {24'h0, bus.mem_dout}, 32'h41);
    check("io_addr", bus.mem_a, 32'h30000);
    @(negedge clk);
    check("io_done", {29'h0, bus.ch_done}, 32'h2);
    check("io_wr_end", {31'h0, bus.mem_wr}, 32'h0);
    bus.ch_valid = 3'b000;

    // ch2 read aborted by flush at byte 2, pending ch0 read follows
    do_reset();
    set_req(2, 1'b0, 32'h200, 3'd4, 32'h0);
    @(negedge clk);
    check("fl_mem_a0", bus.mem_a, 32'h200);
    set_req(0, 1'b0, 32'h300, 3'd1, 32'h0);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    check("fl_no_done", {29'h0, bus.ch_done}, 32'h0);
    flush = 1'b0;
    bus.ch_valid[2] = 1'b0;
    @(negedge clk);
    check("fl_next_grant", bus.mem_a, 32'h300);
    @(negedge clk);
    check("fl_still_no_done", {29'h0, bus.ch_done}, 32'h0);
    @(negedge clk);
    check("fl_ch0_done", {29'h0, bus.ch_done}, 32'h1);
    check("fl_ch0_rdata", bus.ch_rdata, 32'h11);
    bus.ch_valid = 3'b000;

    // ch1 write size 2 is not aborted by flush
    do_reset();
    set_req(1, 1'b1, 32'h400, 3'd2, 32'h0000BEEF);
    @(negedge clk);
    check("wf_b0_addr", bus.mem_a, 32'h400);
    check("wf_b0_data", {24'h0, bus.mem_dout}, 32'hEF);
    flush = 1'b1;
    @(negedge clk);
    check("wf_b1_addr", bus.mem_a, 32'h401);
    check("wf_b1_data", {24'h0, bus.mem_dout}, 32'hBE);
    check("wf_b1_wr", {31'h0, bus.mem_wr}, 32'h1);
    flush = 1'b0;
    @(negedge clk);
    check("wf_done", {29'h0, bus.ch_done}, 32'h2);
    check("wf_wr_end", {31'h0, bus.mem_wr}, 32'h0);
    bus.ch_valid = 3'b000;

    // back-to-back ch0 size-1 reads: done spacing
    do_reset();
    set_req(0, 1'b0, 32'h10, 3'd1, 32'h0);
    got = 0; t_first = 0;
    for (int c = 0; c < 30 && got < 2; c++) begin
      @(negedge clk);
      if (bus.ch_done[0]) begin
        if (got == 0) t_first = cyc;
        else check("b2b_gap", cyc - t_first, EXP_GAP);
        got++;
      end
    end
    bus.ch_valid = 3'b000;
    check("b2b_count", got, 32'd2);

    // rdy low during a write forces mem_wr low and freezes the bus
    do_reset();
    set_req(0, 1'b1, 32'h500, 3'd1, 32'h77);
    @(negedge clk);
    check("st_wr_on", {31'h0, bus.mem_wr}, 32'h1);
    rdy = 1'b0;
    @(negedge clk);
    check("st_wr_forced", {31'h0, bus.mem_wr}, 32'h0);
    check("st_wr_addr", bus.mem_a, 32'h500);
    rdy = 1'b1;
    @(negedge clk);
    check("st_wr_done", {29'h0, bus.ch_done}, 32'h1);
    bus.ch_valid = 3'b000;

    // rdy low during a read holds the byte counter
    do_reset();
    set_req(0, 1'b0, 32'h100, 3'd2, 32'h0);
    @(negedge clk);
    rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("st_rd_addr_hold", bus.mem_a, 32'h100);
    rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("st_rd_done", {29'h0, bus.ch_done}, 32'h1);
    check("st_rd_rdata", bus.ch_rdata, 32'h2211);
    bus.ch_valid = 3'b000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
